// File: rtl/mem_seq_pkg.sv
// Shared types and defaults for the memory-access sequencer.
package mem_seq_pkg;
  localparam int CNT_W_DEF = 32;
  localparam int TMR_W_DEF = 16;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_CMPL, GAP, DONE} seq_state_t;
  typedef enum logic [1:0] {READ = 2'd0, WRITE = 2'd1, ALT = 2'd2} seq_mode_t;

  // The reserved encoding 2'b11 behaves as all-reads.
  function automatic seq_mode_t decode_mode(input logic [1:0] m);
    return (m == 2'd1) ? WRITE : (m == 2'd2) ? ALT : READ;
  endfunction
endpackage

// File: rtl/mem_access_sequencer_if.sv
// Command, completion and debug signals of the sequencer.
interface mem_access_sequencer_if
  import mem_seq_pkg::*;
#(parameter int CNT_W = CNT_W_DEF, parameter int TMR_W = TMR_W_DEF);
  logic             Start;
  logic             Abort;
  logic [1:0]       mode;
  logic [29:0]      base_src_address;
  logic [29:0]      base_dst_address;
  logic [29:0]      stride;
  logic [CNT_W-1:0] num_ops;
  logic [TMR_W-1:0] gap_cycles;
  logic [TMR_W-1:0] timeout_cycles;
  logic             Interrupt;
  logic             GoRead;
  logic             GoWrite;
  logic [29:0]      source_address;
  logic [29:0]      destination_address;
  logic             Busy;
  logic             Done;
  logic             Error;
  logic [CNT_W-1:0] ops_issued;
  logic [CNT_W-1:0] ops_completed;

  // master: the sequencer itself; slave: software control plus the downstream master.
  modport master (
    input  Start, Abort, mode, base_src_address, base_dst_address, stride,
           num_ops, gap_cycles, timeout_cycles, Interrupt,
    output GoRead, GoWrite, source_address, destination_address, Busy, Done,
           Error, ops_issued, ops_completed
  );
  modport slave (
    output Start, Abort, mode, base_src_address, base_dst_address, stride,
           num_ops, gap_cycles, timeout_cycles, Interrupt,
    input  GoRead, GoWrite, source_address, destination_address, Busy, Done,
           Error, ops_issued, ops_completed
  );
endinterface

// File: rtl/seq_cycle_timer.sv
// Loadable down-counter; expired once the count has reached 1 (or sits at 0).
module seq_cycle_timer #(parameter int TMR_W = 16) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] value,
  output logic             expired
);
  logic [TMR_W-1:0] cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)             cnt <= '0;
    else if (load)          cnt <= value;
    else if (cnt != '0)     cnt <= cnt - 1'b1;
  end

  assign expired = (cnt <= TMR_W'(1));
endmodule

// File: rtl/mem_access_sequencer.sv
// Paces a run of N single-beat reads/writes with striding addresses,
// waiting on each completion Interrupt with optional gap and timeout.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(parameter int CNT_W = CNT_W_DEF, parameter int TMR_W = TMR_W_DEF) (
  input logic                    Clk,
  input logic                    Rst_n,
  mem_access_sequencer_if.master bus
);
  seq_state_t       state;
  seq_mode_t        mode_q;
  logic [29:0]      stride_q, src_q, dst_q;
  logic [CNT_W-1:0] num_q, issued_q, completed_q;
  logic [TMR_W-1:0] gap_q, tmo_q;
  logic             last_wr_q, error_q;

  logic cur_wr, last_op, to_issue, gap_load, gap_exp, tmo_exp;
  logic [TMR_W-1:0] tmo_load_val;

  assign cur_wr  = (mode_q == WRITE) || (mode_q == ALT && issued_q[0]);
  assign last_op = (completed_q + CNT_W'(1)) == num_q;

  // Timeout is reloaded on every entry to ISSUE, so it counts from the issue cycle.
  assign to_issue = !bus.Abort &&
    ((state == IDLE      && bus.Start && bus.num_ops != '0) ||
     (state == WAIT_CMPL && bus.Interrupt && !last_op && gap_q == '0) ||
     (state == GAP       && gap_exp));
  assign gap_load     = !bus.Abort && state == WAIT_CMPL && bus.Interrupt;
  assign tmo_load_val = (state == IDLE) ? bus.timeout_cycles : tmo_q;

  seq_cycle_timer #(.TMR_W(TMR_W)) u_gap_tmr (
    .Clk(Clk), .Rst_n(Rst_n), .load(gap_load), .value(gap_q), .expired(gap_exp));
  seq_cycle_timer #(.TMR_W(TMR_W)) u_tmo_tmr (
    .Clk(Clk), .Rst_n(Rst_n), .load(to_issue), .value(tmo_load_val), .expired(tmo_exp));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      mode_q      <= READ;
      stride_q    <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      num_q       <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      gap_q       <= '0;
      tmo_q       <= '0;
      last_wr_q   <= 1'b0;
      error_q     <= 1'b0;
    end else if (bus.Abort) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: if (bus.Start) begin
          mode_q      <= decode_mode(bus.mode);
          stride_q    <= bus.stride;
          num_q       <= bus.num_ops;
          gap_q       <= bus.gap_cycles;
          tmo_q       <= bus.timeout_cycles;
          src_q       <= bus.base_src_address;
          dst_q       <= bus.base_dst_address;
          issued_q    <= '0;
          completed_q <= '0;
          error_q     <= 1'b0;
          state       <= (bus.num_ops == '0) ? DONE : ISSUE;
        end
        ISSUE: begin
          issued_q  <= issued_q + CNT_W'(1);
          last_wr_q <= cur_wr;
          state     <= WAIT_CMPL;
        end
        WAIT_CMPL: begin
          if (bus.Interrupt) begin
            completed_q <= completed_q + CNT_W'(1);
            if (last_wr_q) dst_q <= dst_q + stride_q;
            else           src_q <= src_q + stride_q;
            if (last_op)             state <= DONE;
            else if (gap_q == '0)    state <= ISSUE;
            else                     state <= GAP;
          end else if (tmo_q != '0 && tmo_exp) begin
            error_q <= 1'b1;
            state   <= IDLE;
          end
        end
        GAP:     if (gap_exp) state <= ISSUE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.GoRead              = (state == ISSUE) && !cur_wr;
  assign bus.GoWrite             = (state == ISSUE) &&  cur_wr;
  assign bus.Busy                = (state == ISSUE) || (state == WAIT_CMPL) || (state == GAP);
  assign bus.Done                = (state == DONE);
  assign bus.Error               = error_q;
  assign bus.source_address      = src_q;
  assign bus.destination_address = dst_q;
  assign bus.ops_issued          = issued_q;
  assign bus.ops_completed       = completed_q;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: inputs change 1ns after a rising edge, outputs sampled there.
module tb_mem_access_sequencer;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int tests = 0;
  int failed = 0;

  always #5 Clk = ~Clk;

  mem_access_sequencer_if #(.CNT_W(32), .TMR_W(16)) sif ();
  mem_access_sequencer #(.CNT_W(32), .TMR_W(16)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(sif));

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Drives Start for one cycle; returns in the cycle after Start (ISSUE or DONE).
  task automatic start_run(input logic [1:0] m, input logic [29:0] src, input logic [29:0] dst,
                           input logic [29:0] strd, input int n, input int gap, input int tmo);
    sif.mode = m; sif.base_src_address = src; sif.base_dst_address = dst; sif.stride = strd;
    sif.num_ops = n; sif.gap_cycles = 16'(gap); sif.timeout_cycles = 16'(tmo);
    sif.Start = 1'b1;
    step();
    sif.Start = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    tests++;
    if ({sif.GoRead, sif.GoWrite, sif.Busy, sif.Done, sif.Error} !== 5'b0) begin
      failed++; $display("FAIL reset_flags: got %b want 00000", {sif.GoRead, sif.GoWrite, sif.Busy, sif.Done, sif.Error});
    end
    tests++;
    if (sif.source_address !== 30'h0 || sif.destination_address !== 30'h0 || sif.ops_issued !== 0 || sif.ops_completed !== 0) begin
      failed++; $display("FAIL reset_regs: got src=%h dst=%h iss=%0d cmp=%0d want all 0", sif.source_address, sif.destination_address, sif.ops_issued, sif.ops_completed);
    end
    Rst_n = 1'b1;
    step();
  endtask

  task automatic test_reads();
    logic [29:0] exp_src [3] = '{30'h100, 30'h104, 30'h108};
    start_run(2'b00, 30'h100, 30'h0, 30'd4, 3, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({sif.GoRead, sif.GoWrite, sif.Busy} !== 3'b101 || sif.source_address !== exp_src[k] || sif.ops_issued !== k) begin
        failed++; $display("FAIL reads_issue[%0d]: got go/busy=%b src=%h iss=%0d want 101 src=%h iss=%0d", k, {sif.GoRead, sif.GoWrite, sif.Busy}, sif.source_address, sif.ops_issued, exp_src[k], k);
      end
      step(); step();
      sif.Interrupt = 1'b1;
      step();
      sif.Interrupt = 1'b0;
    end
    tests++;
    if ({sif.GoRead, sif.GoWrite, sif.Busy, sif.Done} !== 4'b0001 || sif.ops_completed !== 3 || sif.ops_issued !== 3) begin
      failed++; $display("FAIL reads_done: got flags=%b cmp=%0d iss=%0d want 0001 cmp=3 iss=3", {sif.GoRead, sif.GoWrite, sif.Busy, sif.Done}, sif.ops_completed, sif.ops_issued);
    end
    step();
    tests++;
    if (sif.Done !== 1'b0 || sif.source_address !== 30'h10c) begin
      failed++; $display("FAIL reads_idle: got done=%b src=%h want done=0 src=10c", sif.Done, sif.source_address);
    end
  endtask

  task automatic test_alternate();
    logic [1:0]  exp_go  [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic [29:0] exp_src [4] = '{30'h200, 30'h210, 30'h210, 30'h220};
    logic [29:0] exp_dst [4] = '{30'h800, 30'h800, 30'h810, 30'h810};
    start_run(2'b10, 30'h200, 30'h800, 30'h10, 4, 2, 0);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({sif.GoRead, sif.GoWrite} !== exp_go[k] || sif.source_address !== exp_src[k] || sif.destination_address !== exp_dst[k]) begin
        failed++; $display("FAIL alt_issue[%0d]: got go=%b src=%h dst=%h want go=%b src=%h dst=%h", k, {sif.GoRead, sif.GoWrite}, sif.source_address, sif.destination_address, exp_go[k], exp_src[k], exp_dst[k]);
      end
      step();
      sif.Interrupt = 1'b1;
      step();
      sif.Interrupt = 1'b0;
      if (k < 3) begin
        step();
        tests++;
        if ({sif.GoRead, sif.GoWrite, sif.Busy} !== 3'b001) begin
          failed++; $display("FAIL alt_gap[%0d]: got go/busy=%b want 001", k, {sif.GoRead, sif.GoWrite, sif.Busy});
        end
        step();
      end
    end
    tests++;
    if (sif.Done !== 1'b1 || sif.source_address !== 30'h220 || sif.destination_address !== 30'h820 || sif.ops_issued !== 4) begin
      failed++; $display("FAIL alt_done: got done=%b src=%h dst=%h iss=%0d want 1 220 820 4", sif.Done, sif.source_address, sif.destination_address, sif.ops_issued);
    end
    step();
  endtask

  task automatic test_timeout();
    start_run(2'b01, 30'h0, 30'h40, 30'd1, 2, 0, 5);
    tests++;
    if (sif.GoWrite !== 1'b1) begin
      failed++; $display("FAIL tmo_issue: got gowrite=%b want 1", sif.GoWrite);
    end
    step(); step(); step(); step();
    tests++;
    if (sif.Error !== 1'b0 || sif.Busy !== 1'b1) begin
      failed++; $display("FAIL tmo_early: got err=%b busy=%b want err=0 busy=1", sif.Error, sif.Busy);
    end
    step();
    tests++;
    if ({sif.Error, sif.Busy, sif.Done} !== 3'b100) begin
      failed++; $display("FAIL tmo_fire: got err/busy/done=%b want 100", {sif.Error, sif.Busy, sif.Done});
    end
    step();
    tests++;
    if (sif.Error !== 1'b1 || sif.Done !== 1'b0 || sif.ops_completed !== 0) begin
      failed++; $display("FAIL tmo_sticky: got err=%b done=%b cmp=%0d want 1 0 0", sif.Error, sif.Done, sif.ops_completed);
    end
    start_run(2'b00, 30'h0, 30'h0, 30'd0, 0, 0, 0);
    tests++;
    if (sif.Error !== 1'b0 || sif.Done !== 1'b1) begin
      failed++; $display("FAIL tmo_clear: got err=%b done=%b want err=0 done=1", sif.Error, sif.Done);
    end
    step();
  endtask

  task automatic test_wrap();
    start_run(2'b11, 30'h3FFFFFFE, 30'h0, 30'd4, 2, 0, 0);
    tests++;
    if (sif.GoRead !== 1'b1 || sif.source_address !== 30'h3FFFFFFE) begin
      failed++; $display("FAIL wrap_first: got goread=%b src=%h want 1 3ffffffe", sif.GoRead, sif.source_address);
    end
    step();
    sif.Interrupt = 1'b1;
    step();
    sif.Interrupt = 1'b0;
    tests++;
    if (sif.GoRead !== 1'b1 || sif.GoWrite !== 1'b0 || sif.source_address !== 30'h2) begin
      failed++; $display("FAIL wrap_second: got go=%b%b src=%h want 10 src=2", sif.GoRead, sif.GoWrite, sif.source_address);
    end
    step();
    sif.Interrupt = 1'b1;
    step();
    sif.Interrupt = 1'b0;
    tests++;
    if (sif.Done !== 1'b1 || sif.ops_completed !== 2) begin
      failed++; $display("FAIL wrap_done: got done=%b cmp=%0d want 1 2", sif.Done, sif.ops_completed);
    end
    step();
  endtask

  task automatic test_zero_and_busy_start();
    start_run(2'b00, 30'h55, 30'h0, 30'd4, 0, 0, 0);
    tests++;
    if ({sif.GoRead, sif.GoWrite, sif.Busy, sif.Done} !== 4'b0001) begin
      failed++; $display("FAIL zero_ops: got flags=%b want 0001", {sif.GoRead, sif.GoWrite, sif.Busy, sif.Done});
    end
    step();
    start_run(2'b00, 30'h40, 30'h0, 30'd4, 1, 0, 0);
    sif.base_src_address = 30'h80; sif.num_ops = 0; sif.Start = 1'b1;
    step(); step();
    sif.Start = 1'b0;
    tests++;
    if (sif.source_address !== 30'h40 || sif.ops_issued !== 1 || {sif.Busy, sif.Done, sif.GoRead} !== 3'b100) begin
      failed++; $display("FAIL busy_start: got src=%h iss=%0d busy/done/go=%b want 40 1 100", sif.source_address, sif.ops_issued, {sif.Busy, sif.Done, sif.GoRead});
    end
    sif.Interrupt = 1'b1;
    step();
    sif.Interrupt = 1'b0;
    tests++;
    if (sif.Done !== 1'b1 || sif.ops_completed !== 1 || sif.source_address !== 30'h44) begin
      failed++; $display("FAIL busy_done: got done=%b cmp=%0d src=%h want 1 1 44", sif.Done, sif.ops_completed, sif.source_address);
    end
    step();
    sif.Interrupt = 1'b1;
    step();
    sif.Interrupt = 1'b0;
    tests++;
    if (sif.ops_completed !== 1 || sif.Busy !== 1'b0 || sif.source_address !== 30'h44) begin
      failed++; $display("FAIL idle_irq: got cmp=%0d busy=%b src=%h want 1 0 44", sif.ops_completed, sif.Busy, sif.source_address);
    end
  endtask

  task automatic test_abort_and_reset();
    start_run(2'b00, 30'h100, 30'h0, 30'd4, 3, 0, 0);
    step();
    sif.Abort = 1'b1; sif.Interrupt = 1'b1;
    step();
    sif.Abort = 1'b0; sif.Interrupt = 1'b0;
    tests++;
    if ({sif.GoRead, sif.GoWrite, sif.Busy, sif.Done} !== 4'b0 || sif.ops_completed !== 0 || sif.ops_issued !== 1 || sif.source_address !== 30'h100) begin
      failed++; $display("FAIL abort: got flags=%b cmp=%0d iss=%0d src=%h want 0000 0 1 100", {sif.GoRead, sif.GoWrite, sif.Busy, sif.Done}, sif.ops_completed, sif.ops_issued, sif.source_address);
    end
    step();
    tests++;
    if (sif.Done !== 1'b0 || sif.Busy !== 1'b0) begin
      failed++; $display("FAIL abort_hold: got done=%b busy=%b want 0 0", sif.Done, sif.Busy);
    end
    start_run(2'b01, 30'h0, 30'h300, 30'd4, 3, 0, 0);
    step();
    #2 Rst_n = 1'b0;
    #1;
    tests++;
    if ({sif.GoRead, sif.GoWrite, sif.Busy, sif.Done, sif.Error} !== 5'b0 || sif.destination_address !== 30'h0 || sif.ops_issued !== 0) begin
      failed++; $display("FAIL async_reset: got flags=%b dst=%h iss=%0d want 00000 0 0", {sif.GoRead, sif.GoWrite, sif.Busy, sif.Done, sif.Error}, sif.destination_address, sif.ops_issued);
    end
    step();
    Rst_n = 1'b1;
    step();
  endtask

  initial begin
    sif.Start = 1'b0; sif.Abort = 1'b0; sif.Interrupt = 1'b0; sif.mode = 2'b00;
    sif.base_src_address = '0; sif.base_dst_address = '0; sif.stride = '0;
    sif.num_ops = '0; sif.gap_cycles = '0; sif.timeout_cycles = '0;
    test_reset();
    test_reads();
    test_alternate();
    test_timeout();
    test_wrap();
    test_zero_and_busy_start();
    test_abort_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Upstream control stage for the single-beat AXI4 memory-access master. It turns one software-level "run N operations" command into a paced series of `GoRead`/`GoWrite` pulses, with per-operation source and destination addresses that advance by a programmable stride. It waits for the master's completion `Interrupt` before issuing the next operation, enforces an optional completion timeout, and keeps issue/complete counters for debug readout.

## Interface
Parameters:
- `CNT_W`, 32: width of `num_ops` and of the issued/completed counters.
- `TMR_W`, 16: width of `gap_cycles` and `timeout_cycles`.

Ports:
- `Clk`, in, 1: single clock. All logic is in this domain.
- `Rst_n`, in, 1: reset, asynchronous and active-low.
- `Start`, in, 1: one-cycle pulse that launches a run. Sampled only in IDLE.
- `Abort`, in, 1: level-sensitive. Forces IDLE from any state.
- `mode`, in, 2: 00 = all reads, 01 = all writes, 10 = alternate (read first), 11 = reserved, treated as 00. Latched at Start.
- `base_src_address`, in, 30: word address of the first read. Latched at Start.
- `base_dst_address`, in, 30: word address of the first write. Latched at Start.
- `stride`, in, 30: word increment applied after each operation of the matching type. Latched at Start.
- `num_ops`, in, CNT_W: total operations in the run. Latched at Start.
- `gap_cycles`, in, TMR_W: idle cycles between a completion and the next issue. Latched at Start.
- `timeout_cycles`, in, TMR_W: completion timeout; 0 disables it. Latched at Start.
- `Interrupt`, in, 1: one-cycle completion pulse from the downstream master.
- `GoRead`, out, 1: one-cycle read launch pulse.
- `GoWrite`, out, 1: one-cycle write launch pulse.
- `source_address`, out, 30: current read address.
- `destination_address`, out, 30: current write address.
- `Busy`, out, 1: high in ISSUE, WAIT_CMPL and GAP.
- `Done`, out, 1: one-cycle pulse at normal run completion.
- `Error`, out, 1: sticky timeout flag. Cleared by the next accepted Start.
- `ops_issued`, out, CNT_W: operations launched in the current run.
- `ops_completed`, out, CNT_W: Interrupts accepted in the current run.

## Operation
- States: IDLE, ISSUE, WAIT_CMPL, GAP, DONE.
- IDLE:
  - On Start, latch all configuration, clear both counters and Error, and load the address registers with the bases.
  - If num_ops = 0, go to DONE; otherwise go to ISSUE.
- ISSUE (exactly one cycle):
  - Assert GoRead or GoWrite. The choice follows mode; in alternate mode it follows bit 0 of `ops_issued` (0 = read).
  - Increment `ops_issued`.
  - Go to WAIT_CMPL and load the timeout timer.
- WAIT_CMPL:
  - On Interrupt, increment `ops_completed` and advance the address of the type just issued by `stride`. Addition is modulo 2^30 and wraps silently.
  - If `ops_completed` + 1 = num_ops, go to DONE.
  - Otherwise, if gap_cycles = 0, go to ISSUE; else go to GAP.
  - If the timer expires with timeout_cycles ≠ 0, set Error and go to IDLE with no Done.
- GAP: count down gap_cycles, then go to ISSUE.
- DONE: one cycle with Done = 1, then IDLE.
- Interrupt received in any state other than WAIT_CMPL is ignored; counters do not change.
- Start received outside IDLE is ignored.
- Abort has priority over every transition, including Interrupt in the same cycle. Abort goes to IDLE with GoRead/GoWrite/Done low. Counters and addresses hold their values for debug; Error is unchanged.
- Interrupt and timer expiry in the same cycle: the Interrupt wins and no Error is set.

## Timing
- Reset values: state = IDLE; all outputs 0, including addresses and counters.
- Start at cycle t → GoX high at t+1 (in ISSUE), addresses equal to the bases.
- GoRead and GoWrite are decoded from the registered state and the op type; they are never both high.
- `source_address` and `destination_address` are registered, stable from ISSUE until the cycle after the accepted Interrupt.
- Interrupt at cycle u:
  - gap = 0 → next GoX at u+1.
  - gap = G → next GoX at u+1+G.
- Timeout: Error rises timeout_cycles cycles after ISSUE if no Interrupt has arrived.
- Last Interrupt at u → Done at u+1, Busy low at u+1, IDLE at u+2.

## Structure
- Package `mem_seq_pkg` holds the state enum `seq_state_t`, the mode enum `seq_mode_t` (READ, WRITE, ALT), and localparam defaults for CNT_W and TMR_W.
- One sub-module, `seq_cycle_timer`: a TMR_W-bit loadable down-counter with `load`, `value` and `expired` ports.
  - Two instances: one for the gap, one for the timeout.

## Test plan
- mode = 00, base_src = 0x100, stride = 4, num_ops = 3, gap = 0; Interrupt 2 cycles after each GoRead → GoRead at cycles 1, 4, 7 with source_address 0x100, 0x104, 0x108; Done one cycle after the third Interrupt; ops_completed = 3.
- mode = 10, num_ops = 4, gap = 2 → pulse order R, W, R, W. Each address advances only after its own type completes. Each GoX lands exactly 3 cycles after the previous Interrupt.
- timeout = 5, Interrupt withheld → Error rises 5 cycles after ISSUE; no Done; a later Start clears Error.
- base_src = 0x3FFFFFFE, stride = 4 → second source_address = 0x00000002 (wrap-around).
- num_ops = 0 → Done 1 cycle after Start, no GoX. Start while Busy → ignored.
- Abort in the same cycle as Interrupt during WAIT_CMPL → IDLE next cycle; ops_completed unchanged; no Done; then mid-run async reset → all outputs 0.
